// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - multi-cycle chunked bitwise logic unit (AND/OR/XOR/NOR)
// Optional registered zero flag enabled by defining LU_ZERO_FLAG_EN.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
`ifdef LU_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    generate
        if (WIDTH <= 0 || CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("logic_unit_seq: WIDTH must be >0 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CHUNK-1:0]  a_chunk, b_chunk, chunk_res;
`ifdef LU_ZERO_FLAG_EN
    logic              zero_q, zero_d;
`endif

    assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

    always_comb begin
        chunk_res = '0;
        case (op_q)
            2'b00:   chunk_res = a_chunk & b_chunk;
            2'b01:   chunk_res = a_chunk | b_chunk;
            2'b10:   chunk_res = a_chunk ^ b_chunk;
            default: chunk_res = ~(a_chunk | b_chunk);
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        idx_d   = idx_q;
`ifdef LU_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    res_d   = '0;
                    idx_d   = '0;
`ifdef LU_ZERO_FLAG_EN
                    zero_d  = 1'b1;
`endif
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                res_d[idx_q*CHUNK +: CHUNK] = chunk_res;
`ifdef LU_ZERO_FLAG_EN
                zero_d = zero_q & (chunk_res == '0);
`endif
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                // out_ready only matters here; earlier assertion is simply ignored
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            idx_q   <= '0;
`ifdef LU_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
`ifdef LU_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
`ifdef LU_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - self-checking bench for logic_unit_seq
module tb_logic_unit_seq;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
`ifdef LU_ZERO_FLAG_EN
    logic             zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
`ifdef LU_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    typedef struct {
        string            name;
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_res;
    } vec_t;

    vec_t vecs[4];

    // Whole-word reference: the chunking is invisible at this level
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        return WIDTH'({$urandom, $urandom});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int guard;
        guard = 0;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1'b1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [1:0] o,
                                 input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] exp_res);
        int lat;
        out_ready = 1'b1;
        start_op(o, x, y);
        wait_done(lat);
        check({name, "_latency"}, lat, NCHUNK);
        check({name, "_res"}, res, exp_res);
`ifdef LU_ZERO_FLAG_EN
        check({name, "_zero"}, zero, (exp_res == '0));
`endif
        @(negedge clk);
        check({name, "_idle_ready"}, in_ready, 1'b1);
        check({name, "_idle_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               lat;
        logic             stale;
        logic [1:0]       ro;
        logic [WIDTH-1:0] rx, ry, exp;

        vecs[0] = '{"or_basic",  2'b01, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F};
        vecs[1] = '{"nor_zero",  2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{"and_disj",  2'b00, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000};
        vecs[3] = '{"xor_same",  2'b10, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_res", res, '0);
`ifdef LU_ZERO_FLAG_EN
        check("rst_zero", zero, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res);

        // Stall in DONE with a competing request
        out_ready = 1'b0;
        start_op(2'b00, 32'hFFFF0000, 32'h0F0FFFFF);
        wait_done(lat);
        check("stall_latency", lat, NCHUNK);
        a = 32'h12345678; b = 32'h9ABCDEF0; op = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_res", res, 32'h0F0F0000);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", in_ready, 1'b1);
        check("stall_release_valid", out_valid, 1'b0);

        // Operand ports churn while busy; result must reflect latched values
        rx = 32'hC3C3_5A5A; ry = 32'h0FF0_33CC;
        start_op(2'b10, rx, ry);
        lat = 0;
        while (!out_valid && lat < 64) begin
            a = rand_word(); b = rand_word(); op = 2'($urandom_range(0, 3)); in_valid = 1'b1;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("churn_latency", lat, NCHUNK);
        check("churn_res", res, model(2'b10, rx, ry));
        @(negedge clk);
        check("churn_idle", in_ready, 1'b1);

        // Asynchronous reset in the second busy cycle
        start_op(2'b01, '1, '0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res", res, '0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 2 * NCHUNK + 4; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("arst_no_stale", stale, 1'b0);
        check("arst_res_after", res, '0);

        // Random vectors against the whole-word model
        for (int i = 0; i < 300; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = rand_word();
            case ($urandom_range(0, 3))
                0:       ry = rx;
                1:       ry = ~rx;
                default: ry = rand_word();
            endcase
            exp = model(ro, rx, ry);
            run_and_check("rand", ro, rx, ry, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
